// File: rtl/instruction_fetch.sv
// Fetch stage: PC register, IF/ID pipeline register and delivered-instruction counter.
// Define IF_JAL_EARLY_EN to redirect on jal directly in fetch.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        jump_flag_ex,
  input  logic [31:0] jump_address_ex,
  output logic [31:0] imem_address,
  input  logic [31:0] imem_data,
  output logic [31:0] instruction_id,
  output logic [31:0] instruction_address_id,
  output logic        pre_jump_flag_id,
  output logic        early_jump_id,
  output logic [31:0] fetch_count
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] instr_addr_q, instr_addr_d;
  logic        early_q, early_d;
  logic [31:0] count_q, count_d;

  logic [31:0] pc_plus4;
  logic        is_jal;
  logic [31:0] jal_target;

  assign pc_plus4 = pc_q + 32'd4;

`ifdef IF_JAL_EARLY_EN
  logic [31:0] j_imm;
  assign is_jal     = (imem_data[6:0] == 7'b1101111);
  assign j_imm      = {{11{imem_data[31]}}, imem_data[31], imem_data[19:12], imem_data[20],
                       imem_data[30:21], 1'b0};
  assign jal_target = pc_q + j_imm;
`else
  assign is_jal     = 1'b0;
  assign jal_target = pc_plus4;
`endif

  always_comb begin
    pc_d         = pc_q;
    instr_d      = instr_q;
    instr_addr_d = instr_addr_q;
    early_d      = early_q;
    count_d      = count_q;
    if (jump_flag_ex) begin
      // Redirect wins over stall; the slot handed to decode becomes a bubble.
      pc_d    = jump_address_ex & 32'hFFFF_FFFC;
      instr_d = NOP_WORD;
      early_d = 1'b0;
    end else if (!stall) begin
      pc_d         = is_jal ? jal_target : pc_plus4;
      instr_d      = imem_data;
      instr_addr_d = pc_q;
      early_d      = is_jal;
      count_d      = count_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q         <= RESET_PC;
      instr_q      <= NOP_WORD;
      instr_addr_q <= 32'h0;
      early_q      <= 1'b0;
      count_q      <= 32'h0;
    end else begin
      pc_q         <= pc_d;
      instr_q      <= instr_d;
      instr_addr_q <= instr_addr_d;
      early_q      <= early_d;
      count_q      <= count_d;
    end
  end

  assign imem_address           = pc_q;
  assign instruction_id         = instr_q;
  assign instruction_address_id = instr_addr_q;
  assign early_jump_id          = early_q;
  assign fetch_count            = count_q;
  assign pre_jump_flag_id       = jump_flag_ex;

endmodule

// File: tb/tb_instruction_fetch.sv
// Scoreboard bench for instruction_fetch: driver queues expected post-edge state,
// monitor compares after each rising edge.
module tb_instruction_fetch;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        jump_flag_ex;
  logic [31:0] jump_address_ex;
  logic [31:0] imem_address;
  logic [31:0] imem_data;
  logic [31:0] instruction_id;
  logic [31:0] instruction_address_id;
  logic        pre_jump_flag_id;
  logic        early_jump_id;
  logic [31:0] fetch_count;

  int tests;
  int fails;

  typedef struct {
    string       name;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] addr;
    logic        early;
    logic [31:0] count;
  } exp_t;

  exp_t sb[$];

  instruction_fetch dut (
    .clk                    (clk),
    .rst                    (rst),
    .stall                  (stall),
    .jump_flag_ex           (jump_flag_ex),
    .jump_address_ex        (jump_address_ex),
    .imem_address           (imem_address),
    .imem_data              (imem_data),
    .instruction_id         (instruction_id),
    .instruction_address_id (instruction_address_id),
    .pre_jump_flag_id       (pre_jump_flag_id),
    .early_jump_id          (early_jump_id),
    .fetch_count            (fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: state after each rising edge is compared against the oldest expectation.
  always @(posedge clk) begin
    #2;
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      check({e.name, ".pc"},    imem_address,           e.pc);
      check({e.name, ".instr"}, instruction_id,         e.instr);
      check({e.name, ".addr"},  instruction_address_id, e.addr);
      check({e.name, ".early"}, {31'b0, early_jump_id}, {31'b0, e.early});
      check({e.name, ".count"}, fetch_count,            e.count);
    end
  end

  // Called at a falling edge: drive one cycle of inputs and queue the expected result.
  task automatic step(input string name, input logic st, input logic jf, input logic [31:0] ja,
                      input logic [31:0] data, input logic [31:0] e_pc,
                      input logic [31:0] e_instr, input logic [31:0] e_addr,
                      input logic e_early, input logic [31:0] e_cnt);
    exp_t e;
    stall           = st;
    jump_flag_ex    = jf;
    jump_address_ex = ja;
    imem_data       = data;
    e.name  = name;
    e.pc    = e_pc;
    e.instr = e_instr;
    e.addr  = e_addr;
    e.early = e_early;
    e.count = e_cnt;
    sb.push_back(e);
    #1;
    check({name, ".pre_jump"}, {31'b0, pre_jump_flag_id}, {31'b0, jf});
    @(negedge clk);
  endtask

  logic [31:0] jal_next;
  logic        jal_early;

  initial begin
    tests           = 0;
    fails           = 0;
    rst             = 1'b1;
    stall           = 1'b0;
    jump_flag_ex    = 1'b0;
    jump_address_ex = 32'h0;
    imem_data       = 32'h13;
`ifdef IF_JAL_EARLY_EN
    jal_next  = 32'h18;
    jal_early = 1'b1;
`else
    jal_next  = 32'h14;
    jal_early = 1'b0;
`endif

    #2;
    check("reset.pc",    imem_address,           32'h0);
    check("reset.instr", instruction_id,         32'h13);
    check("reset.addr",  instruction_address_id, 32'h0);
    check("reset.early", {31'b0, early_jump_id}, 32'h0);
    check("reset.count", fetch_count,            32'h0);

    @(negedge clk);
    rst = 1'b0;
    //    name        st    jf    target        data          pc            instr         addr          e     cnt
    step("fetch0",   1'b0, 1'b0, 32'h0,        32'h13,       32'h4,        32'h13,       32'h0,        1'b0, 32'd1);
    step("fetch4",   1'b0, 1'b0, 32'h0,        32'h00100093, 32'h8,        32'h00100093, 32'h4,        1'b0, 32'd2);
    step("stall1",   1'b1, 1'b0, 32'h0,        32'h00200113, 32'h8,        32'h00100093, 32'h4,        1'b0, 32'd2);
    step("stall2",   1'b1, 1'b0, 32'h0,        32'h00200113, 32'h8,        32'h00100093, 32'h4,        1'b0, 32'd2);
    step("resume8",  1'b0, 1'b0, 32'h0,        32'h00200113, 32'hC,        32'h00200113, 32'h8,        1'b0, 32'd3);
    step("fetchC",   1'b0, 1'b0, 32'h0,        32'h13,       32'h10,       32'h13,       32'hC,        1'b0, 32'd4);
    step("jal10",    1'b0, 1'b0, 32'h0,        32'h0080006F, jal_next,     32'h0080006F, 32'h10,       jal_early, 32'd5);
    step("jumpstl",  1'b1, 1'b1, 32'h102,      32'h33,       32'h100,      32'h13,       32'h10,       1'b0, 32'd5);
    step("fetch100", 1'b0, 1'b0, 32'h0,        32'h33,       32'h104,      32'h33,       32'h100,      1'b0, 32'd6);
    step("jumptop",  1'b0, 1'b1, 32'hFFFFFFFF, 32'h33,       32'hFFFFFFFC, 32'h13,       32'h100,      1'b0, 32'd6);
    step("wrap",     1'b0, 1'b0, 32'h0,        32'h13,       32'h0,        32'h13,       32'hFFFFFFFC, 1'b0, 32'd7);

    // Asynchronous reset in the middle of a redirect cycle, away from any clock edge.
    jump_flag_ex    = 1'b1;
    jump_address_ex = 32'h200;
    #2;
    rst = 1'b1;
    #1;
    check("rstjump.pc",    imem_address,           32'h0);
    check("rstjump.instr", instruction_id,         32'h13);
    check("rstjump.addr",  instruction_address_id, 32'h0);
    check("rstjump.early", {31'b0, early_jump_id}, 32'h0);
    check("rstjump.count", fetch_count,            32'h0);
    @(negedge clk);
    rst = 1'b0;
    step("postrst",  1'b0, 1'b0, 32'h0,        32'h00500293, 32'h4,        32'h00500293, 32'h0,        1'b0, 32'd1);

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
    if (sb.size() > 0) begin
      tests++;
      fails++;
      $display("FAIL drain: %0d expectations left, 0 required", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
